envelope_adsr: RTL and testbench
================================

Name: envelope_adsr

Overview:
Parametrised successor to the dynamics block: a beat-clocked ADSR amplitude envelope generator for one voice.
- On new_note it latches the note's peak amplitude and timing, then steps amplitude_out through attack, decay, sustain and release.
- Sits between the note sequencer and the waveform scaler.
- Adds sustain level, release phase, legato retrigger and generic widths.

Parameters:
AMP_W, 3, amplitude width (peak, sustain, output)
TIME_W, 6, width of duration/attack/decay/release beat counts

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
amplitude_in  in  AMP_W  peak amplitude, latched on new_note
duration  in  TIME_W  note length in beats; 0 = hold until next new_note
attack  in  TIME_W  beats per +1 amplitude step; 0 = jump to peak
decay  in  TIME_W  beats per -1 step toward sustain; 0 = jump
sustain  in  AMP_W  sustain level, clamped to min(sustain, peak)
release  in  TIME_W  beats per -1 step toward 0; 0 = jump to 0
new_note  in  1  single-cycle note start
beat  in  1  single-cycle time tick
amplitude_out  out  AMP_W  registered envelope amplitude
stage  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
busy  out  1  stage != IDLE

Behaviour:
- Reset (async, any time, mid-note included): amplitude_out=0, stage=IDLE, busy=0, all counters 0.
- All outputs registered. new_note at edge N -> stage=ATTACK at N+1. If attack==0, amplitude_out=peak at N+1.
- new_note latches all inputs, clears the elapsed and rate counters, and enters ATTACK from the current amplitude_out (legato). It overrides any state. A coincident beat is not counted.
- Rate counter: increments on each beat. When counter+1 == the stage's rate value, apply one amplitude step and clear the counter. Rate 0 applies the full jump on the next edge, no beat needed.
- ATTACK: +1 per step. At amp >= peak -> DECAY, counter cleared. If amp > peak on retrigger -> DECAY immediately.
- DECAY: -1 per step. At amp <= sustain_clamped -> SUSTAIN.
- SUSTAIN: hold amplitude.
- Elapsed counter (TIME_W bits, saturating):
  - Increments on beat in ATTACK, DECAY and SUSTAIN.
  - The beat on which elapsed+1 == duration (duration != 0) forces RELEASE from any of those stages, from the current amp, rate counter cleared.
  - This check has priority over the same-beat stage step.
- RELEASE: -1 per step. At amp == 0 -> IDLE. If release==0: amp=0 and stage=IDLE on the entry edge. Entering RELEASE with amp==0 -> IDLE.
- Amplitude never wraps: increments stop at peak, decrements stop at their targets. peak==0 yields ATTACK -> DECAY -> SUSTAIN at 0.
- beat in IDLE: ignored.

Optional Feature:
NOTE_OFF_EN
- Defined: adds input port note_off (1 bit). In ATTACK, DECAY or SUSTAIN it forces RELEASE on the next edge, same as duration expiry. new_note has priority over note_off.
- Undefined: no port; release is triggered by duration only.

Decomposition:
- Shared package dynamics_pkg: stage encoding localparams (IDLE..RELEASE) and stage width 3.
- One sub-module, rate_timer:
  - Holds the TIME_W beat counter with clear, beat and rate inputs.
  - step output pulses on count match, or every cycle when rate==0.
  - Shared by attack, decay and release.

Test Plan:
- Reset asserted mid-ATTACK with amp=2 -> amplitude_out=0, stage=0, busy=0 immediately; stays IDLE after release of reset.
- amp=4, sustain=4, attack=0, decay=0, release=0, duration=3, new_note -> amp=4 next cycle; ATTACK -> DECAY -> SUSTAIN; on 3rd beat amp=0, stage=IDLE.
- amp=4, attack=2, duration=0 -> amp rises 1 every 2 beats and reaches 4 on beat 8; no release while held.
- peak=6, attack=0, decay=1, sustain=2 -> amp falls 6,5,4,3,2 on successive beats, then SUSTAIN.
- In RELEASE at amp=3, new_note with peak=5, attack=1 -> ATTACK from 3; amp=4 on 1st beat and 5 on 2nd, then DECAY.
- new_note and beat in the same cycle, duration=1 -> beat not counted; release on the next beat.

Source files
------------

// File: rtl/dynamics_pkg.sv
// Stage encoding shared by the envelope generator and anything that decodes its stage output.
package dynamics_pkg;

    localparam int STAGE_W = 3;

    localparam logic [STAGE_W-1:0] STAGE_IDLE    = 3'd0;
    localparam logic [STAGE_W-1:0] STAGE_ATTACK  = 3'd1;
    localparam logic [STAGE_W-1:0] STAGE_DECAY   = 3'd2;
    localparam logic [STAGE_W-1:0] STAGE_SUSTAIN = 3'd3;
    localparam logic [STAGE_W-1:0] STAGE_RELEASE = 3'd4;

    typedef enum logic [STAGE_W-1:0] {
        S_IDLE    = STAGE_IDLE,
        S_ATTACK  = STAGE_ATTACK,
        S_DECAY   = STAGE_DECAY,
        S_SUSTAIN = STAGE_SUSTAIN,
        S_RELEASE = STAGE_RELEASE
    } stage_e;

endpackage

// File: rtl/rate_timer.sv
// Beat counter that pulses step_o every rate_i beats, or every cycle when rate_i is 0.
module rate_timer #(
    parameter int TIME_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              beat_i,
    input  logic [TIME_W-1:0] rate_i,
    output logic              step_o
);

    logic [TIME_W-1:0] count_q;
    logic [TIME_W-1:0] count_d;

    assign step_o = (rate_i == '0) || (beat_i && ((count_q + TIME_W'(1)) == rate_i));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (step_o) begin
            count_d = '0;
        end else if (beat_i) begin
            count_d = count_q + TIME_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/envelope_adsr.sv
// Beat-clocked ADSR envelope for one voice; NOTE_OFF_EN adds a note_off input that forces release.
// The release rate port is called release_time because "release" is a reserved word.
module envelope_adsr
    import dynamics_pkg::*;
#(
    parameter int AMP_W  = 3,
    parameter int TIME_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AMP_W-1:0]   amplitude_in,
    input  logic [TIME_W-1:0]  duration,
    input  logic [TIME_W-1:0]  attack,
    input  logic [TIME_W-1:0]  decay,
    input  logic [AMP_W-1:0]   sustain,
    input  logic [TIME_W-1:0]  release_time,
    input  logic               new_note,
    input  logic               beat,
`ifdef NOTE_OFF_EN
    input  logic               note_off,
`endif
    output logic [AMP_W-1:0]   amplitude_out,
    output logic [STAGE_W-1:0] stage,
    output logic               busy
);

    stage_e            stage_q, stage_d;
    logic [AMP_W-1:0]  amp_q, amp_d;
    logic              busy_q, busy_d;
    logic [AMP_W-1:0]  peak_q, peak_d;
    logic [AMP_W-1:0]  sus_q, sus_d;
    logic [TIME_W-1:0] dur_q, dur_d;
    logic [TIME_W-1:0] att_q, att_d;
    logic [TIME_W-1:0] dec_q, dec_d;
    logic [TIME_W-1:0] rel_q, rel_d;
    logic [TIME_W-1:0] elapsed_q, elapsed_d;

    logic              active;
    logic              expire;
    logic              off_req;
    logic              rel_trig;
    logic              t_clear;
    logic              t_beat;
    logic [TIME_W-1:0] t_rate;
    logic              step;

    assign active = (stage_q == S_ATTACK) || (stage_q == S_DECAY) || (stage_q == S_SUSTAIN);
    assign expire = active && beat && (dur_q != '0) && ((elapsed_q + TIME_W'(1)) == dur_q);

`ifdef NOTE_OFF_EN
    assign off_req = active && note_off;
`else
    assign off_req = 1'b0;
`endif

    assign rel_trig = expire || off_req;

    // The timer only sees beats in the stages that move the amplitude; new_note swallows its beat.
    always_comb begin
        t_rate = '0;
        case (stage_q)
            S_ATTACK:  t_rate = att_q;
            S_DECAY:   t_rate = dec_q;
            S_RELEASE: t_rate = rel_q;
            default:   t_rate = '0;
        endcase
    end

    assign t_beat  = beat && !new_note &&
                     ((stage_q == S_ATTACK) || (stage_q == S_DECAY) || (stage_q == S_RELEASE));
    assign t_clear = new_note || (stage_d != stage_q);

    rate_timer #(.TIME_W(TIME_W)) u_rate_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (t_clear),
        .beat_i  (t_beat),
        .rate_i  (t_rate),
        .step_o  (step)
    );

    always_comb begin
        stage_d   = stage_q;
        amp_d     = amp_q;
        peak_d    = peak_q;
        sus_d     = sus_q;
        dur_d     = dur_q;
        att_d     = att_q;
        dec_d     = dec_q;
        rel_d     = rel_q;
        elapsed_d = elapsed_q;

        if (new_note) begin
            // Legato: keep the current amplitude unless attack is instant.
            peak_d    = amplitude_in;
            sus_d     = (sustain < amplitude_in) ? sustain : amplitude_in;
            dur_d     = duration;
            att_d     = attack;
            dec_d     = decay;
            rel_d     = release_time;
            elapsed_d = '0;
            stage_d   = S_ATTACK;
            if (attack == '0) begin
                amp_d = amplitude_in;
            end
        end else begin
            if (active && beat && (elapsed_q != '1)) begin
                elapsed_d = elapsed_q + TIME_W'(1);
            end

            if (rel_trig) begin
                if ((rel_q == '0) || (amp_q == '0)) begin
                    stage_d = S_IDLE;
                    amp_d   = '0;
                end else begin
                    stage_d = S_RELEASE;
                end
            end else begin
                case (stage_q)
                    S_ATTACK: begin
                        if (amp_q >= peak_q) begin
                            stage_d = S_DECAY;
                        end else if (step) begin
                            amp_d = (att_q == '0) ? peak_q : amp_q + AMP_W'(1);
                        end
                    end
                    S_DECAY: begin
                        if (amp_q <= sus_q) begin
                            stage_d = S_SUSTAIN;
                        end else if (step) begin
                            amp_d = (dec_q == '0) ? sus_q : amp_q - AMP_W'(1);
                        end
                    end
                    S_RELEASE: begin
                        if (amp_q == '0) begin
                            stage_d = S_IDLE;
                        end else if (step) begin
                            if ((rel_q == '0) || (amp_q == AMP_W'(1))) begin
                                amp_d   = '0;
                                stage_d = S_IDLE;
                            end else begin
                                amp_d = amp_q - AMP_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        busy_d = (stage_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q   <= S_IDLE;
            amp_q     <= '0;
            busy_q    <= 1'b0;
            peak_q    <= '0;
            sus_q     <= '0;
            dur_q     <= '0;
            att_q     <= '0;
            dec_q     <= '0;
            rel_q     <= '0;
            elapsed_q <= '0;
        end else begin
            stage_q   <= stage_d;
            amp_q     <= amp_d;
            busy_q    <= busy_d;
            peak_q    <= peak_d;
            sus_q     <= sus_d;
            dur_q     <= dur_d;
            att_q     <= att_d;
            dec_q     <= dec_d;
            rel_q     <= rel_d;
            elapsed_q <= elapsed_d;
        end
    end

    assign amplitude_out = amp_q;
    assign stage         = stage_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_envelope_adsr.sv
// Self-checking bench for envelope_adsr: vector table, corner-case sequences, random run against a model.
module tb_envelope_adsr;

    localparam int AMP_W  = 3;
    localparam int TIME_W = 6;
    localparam int TMAX   = (1 << TIME_W) - 1;

    logic              clk;
    logic              reset;
    logic [AMP_W-1:0]  amplitude_in;
    logic [TIME_W-1:0] duration;
    logic [TIME_W-1:0] attack;
    logic [TIME_W-1:0] decay;
    logic [AMP_W-1:0]  sustain;
    logic [TIME_W-1:0] release_time;
    logic              new_note;
    logic              beat;
    logic [AMP_W-1:0]  amplitude_out;
    logic [2:0]        stage;
    logic              busy;

    int checks = 0;
    int errors = 0;

    envelope_adsr #(.AMP_W(AMP_W), .TIME_W(TIME_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .amplitude_in  (amplitude_in),
        .duration      (duration),
        .attack        (attack),
        .decay         (decay),
        .sustain       (sustain),
        .release_time  (release_time),
        .new_note      (new_note),
        .beat          (beat),
        .amplitude_out (amplitude_out),
        .stage         (stage),
        .busy          (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: envelope as an amplitude moving toward a stage target
    int m_stage, m_amp, m_cnt, m_el;
    int p_peak, p_sus, p_att, p_dec, p_rel, p_dur;

    task automatic model_reset();
        m_stage = 0; m_amp = 0; m_cnt = 0; m_el = 0;
        p_peak = 0; p_sus = 0; p_att = 0; p_dec = 0; p_rel = 0; p_dur = 0;
    endtask

    task automatic model_edge(input bit nn, input bit bt);
        int  tgt;
        int  rate;
        bit  expire;
        if (nn) begin
            p_peak = int'(amplitude_in);
            p_sus  = (int'(sustain) < p_peak) ? int'(sustain) : p_peak;
            p_att  = int'(attack);
            p_dec  = int'(decay);
            p_rel  = int'(release_time);
            p_dur  = int'(duration);
            m_el = 0; m_cnt = 0; m_stage = 1;
            if (p_att == 0) m_amp = p_peak;
            return;
        end
        if (m_stage == 0) return;
        if (m_stage != 4 && bt) begin
            expire = (p_dur != 0) && (m_el + 1 == p_dur);
            if (m_el < TMAX) m_el++;
            if (expire) begin
                m_cnt = 0;
                if (p_rel == 0 || m_amp == 0) begin
                    m_stage = 0; m_amp = 0;
                end else begin
                    m_stage = 4;
                end
                return;
            end
        end
        if (m_stage == 3) return;
        if (m_stage == 1 && m_amp >= p_peak) begin m_stage = 2; m_cnt = 0; return; end
        if (m_stage == 2 && m_amp <= p_sus)  begin m_stage = 3; m_cnt = 0; return; end
        tgt  = (m_stage == 1) ? p_peak : (m_stage == 2) ? p_sus : 0;
        rate = (m_stage == 1) ? p_att  : (m_stage == 2) ? p_dec : p_rel;
        if (rate == 0) begin
            m_amp = tgt;
        end else if (bt) begin
            m_cnt++;
            if (m_cnt == rate) begin
                m_amp = m_amp + ((tgt > m_amp) ? 1 : -1);
                m_cnt = 0;
            end
        end
        if (m_stage == 4 && m_amp == 0) begin m_stage = 0; m_cnt = 0; end
    endtask

    // scoreboard helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int exp_amp, input int exp_stage);
        check({name, " amp"},   32'(amplitude_out), 32'(exp_amp));
        check({name, " stage"}, 32'(stage),         32'(exp_stage));
        check({name, " busy"},  32'(busy),          32'(exp_stage != 0));
    endtask

    // driver tasks
    task automatic cyc(input bit nn, input bit bt);
        new_note = nn;
        beat     = bt;
        model_edge(nn, bt);
        @(posedge clk);
        #1;
        new_note = 1'b0;
        beat     = 1'b0;
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_note(input int pk, input int su, input int at, input int de,
                            input int re, input int du);
        amplitude_in = AMP_W'(pk);
        sustain      = AMP_W'(su);
        attack       = TIME_W'(at);
        decay        = TIME_W'(de);
        release_time = TIME_W'(re);
        duration     = TIME_W'(du);
    endtask

    typedef struct {
        int peak, sus, att, dec, rel, dur;
        int nbeats;
        int exp_amp, exp_stage;
    } vec_t;

    vec_t tbl[15];

    initial begin
        reset = 1'b1; new_note = 1'b0; beat = 1'b0;
        set_note(0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        check_out("reset", 0, 0);

        // settled outputs after new_note plus N beats, each followed by quiet cycles
        tbl[0]  = '{4, 4, 0, 0, 0, 3,  0, 4, 3};
        tbl[1]  = '{4, 4, 0, 0, 0, 3,  2, 4, 3};
        tbl[2]  = '{4, 4, 0, 0, 0, 3,  3, 0, 0};
        tbl[3]  = '{4, 4, 2, 0, 0, 0,  7, 3, 1};
        tbl[4]  = '{4, 4, 2, 0, 0, 0,  8, 4, 3};
        tbl[5]  = '{6, 2, 0, 1, 0, 0,  3, 3, 2};
        tbl[6]  = '{6, 2, 0, 1, 0, 0,  4, 2, 3};
        tbl[7]  = '{5, 7, 0, 0, 2, 2,  1, 5, 3};
        tbl[8]  = '{5, 7, 0, 0, 2, 2,  2, 5, 4};
        tbl[9]  = '{5, 7, 0, 0, 2, 2,  4, 4, 4};
        tbl[10] = '{0, 3, 3, 3, 1, 0,  2, 0, 3};
        tbl[11] = '{7, 3, 1, 2, 1, 10, 9, 6, 2};
        tbl[12] = '{7, 3, 1, 2, 1, 10, 10, 6, 4};
        tbl[13] = '{7, 3, 1, 2, 1, 10, 13, 3, 4};
        tbl[14] = '{2, 1, 0, 0, 1, 1,  2, 0, 0};

        for (int i = 0; i < 15; i++) begin
            do_reset();
            set_note(tbl[i].peak, tbl[i].sus, tbl[i].att, tbl[i].dec, tbl[i].rel, tbl[i].dur);
            cyc(1'b1, 1'b0);
            quiet(4);
            for (int b = 0; b < tbl[i].nbeats; b++) begin
                cyc(1'b0, 1'b1);
                quiet(4);
            end
            check_out($sformatf("vec%0d", i), tbl[i].exp_amp, tbl[i].exp_stage);
        end

        // async reset in the middle of an attack
        do_reset();
        set_note(4, 4, 2, 0, 0, 0);
        cyc(1'b1, 1'b0);
        for (int b = 0; b < 4; b++) begin
            cyc(1'b0, 1'b1);
            quiet(1);
        end
        check_out("pre_reset", 2, 1);
        #3;
        reset = 1'b1;
        #1;
        check_out("async_reset", 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int b = 0; b < 3; b++) cyc(1'b0, 1'b1);
        check_out("post_reset_idle", 0, 0);

        // legato retrigger from release at amplitude 3
        do_reset();
        set_note(5, 5, 0, 0, 1, 1);
        cyc(1'b1, 1'b0);
        quiet(4);
        check_out("legato_sustain", 5, 3);
        cyc(1'b0, 1'b1);
        check_out("legato_rel_entry", 5, 4);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        check_out("legato_rel3", 3, 4);
        set_note(5, 2, 1, 3, 1, 0);
        cyc(1'b1, 1'b0);
        check_out("legato_attack", 3, 1);
        cyc(1'b0, 1'b1);
        check_out("legato_beat1", 4, 1);
        cyc(1'b0, 1'b1);
        check_out("legato_beat2", 5, 1);
        cyc(1'b0, 1'b0);
        check_out("legato_decay", 5, 2);

        // beat coincident with new_note is not counted
        do_reset();
        set_note(3, 3, 0, 0, 0, 1);
        cyc(1'b1, 1'b1);
        check_out("coinc_attack", 3, 1);
        quiet(4);
        check_out("coinc_held", 3, 3);
        cyc(1'b0, 1'b1);
        check_out("coinc_release", 0, 0);

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            amplitude_in = AMP_W'($urandom_range(0, 7));
            sustain      = AMP_W'($urandom_range(0, 7));
            attack       = TIME_W'($urandom_range(0, 3));
            decay        = TIME_W'($urandom_range(0, 3));
            release_time = TIME_W'($urandom_range(0, 3));
            duration     = TIME_W'($urandom_range(0, 8));
            cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 2) == 0));
            check_out($sformatf("rand%0d", n), m_amp, m_stage);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
